button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 151 +++++++++++++++
 tb/tb_button_debouncer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces a raw mechanical push-button. The raw input is brought into the
// clk domain through a two-flop synchroniser. A four-state FSM then accepts a
// new level only after it has been seen without interruption on
// DEBOUNCE_CYCLES+1 consecutive synchronised samples. Any sample at the old
// level restarts the count from zero. Accepted edges produce one-cycle
// btn_rise / btn_fall pulses.
// Optional feature: define DEBOUNCE_TOGGLE_EN to add btn_toggle, a level
// that inverts on every accepted press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000000,
  parameter int unsigned CNT_W           = 24,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic btn_toggle
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam state_e           RST_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Two-flop synchroniser; only s2_q is used by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= INIT_LEVEL;
      s2_q <= INIT_LEVEL;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: count consecutive samples at the candidate level and
  // accept once the counter reaches DEBOUNCE_CYCLES. The counter never
  // exceeds DEBOUNCE_CYCLES, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        level_d = INIT_LEVEL;
      end
    endcase
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  // Toggle flop flips on the same edge that raises btn_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
    end else if (rise_d) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign btn_toggle = toggle_q;
`endif

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4, INIT_LEVEL=0.
// Stimulus pushes the edge number at which each accepted pulse must appear
// (sample edge + DEBOUNCE_CYCLES + 2). The monitor compares btn_rise,
// btn_fall and btn_level (and btn_toggle when built with the toggle macro)
// against that schedule on every falling clock edge.
module tb_button_debouncer;

  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level, btn_rise, btn_fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic btn_toggle;
`endif

  typedef struct {
    int edge_n;
    bit rise;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_er, mon_ef;
  logic exp_level  = 1'b0;
  logic exp_toggle = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  int   k;
  bit   bvec [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8),
    .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .btn_toggle(btn_toggle)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number e, cyc == e until the next posedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, req);
  endtask

  // Drive a level at a falling edge and hold it for 'hold' cycles; when
  // 'push' is set the level is expected to be accepted LAT edges after the
  // edge that samples it.
  task automatic drive(input logic v, input int hold, input bit push);
    exp_t e;
    @(negedge clk);
    btn_raw = v;
    if (push) begin
      e.edge_n = cyc + 1 + LAT;
      e.rise   = v;
      sb.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  // Monitor: pops the scheduled pulse when its edge arrives and checks all
  // outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      mon_er = 1'b0;
      mon_ef = 1'b0;
      if (!rst_n) begin
        exp_level  = 1'b0;
        exp_toggle = 1'b0;
      end else if (sb.size() > 0 && sb[0].edge_n == cyc) begin
        mon_e     = sb.pop_front();
        mon_er    = mon_e.rise;
        mon_ef    = !mon_e.rise;
        exp_level = mon_e.rise;
        if (mon_e.rise) exp_toggle = !exp_toggle;
      end
      check("btn_rise", btn_rise, mon_er);
      check("btn_fall", btn_fall, mon_ef);
      check("btn_level", btn_level, exp_level);
`ifdef DEBOUNCE_TOGGLE_EN
      check("btn_toggle", btn_toggle, exp_toggle);
`endif
    end
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    #1;
    check("reset_level", btn_level, 1'b0);
    check("reset_rise", btn_rise, 1'b0);
    check("reset_fall", btn_fall, 1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
    check("reset_toggle", btn_toggle, 1'b0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Quiet input: nothing may happen.
    drive(1'b0, 20, 1'b0);

    // Clean step up and back down.
    drive(1'b1, 12, 1'b1);
    drive(1'b0, 12, 1'b1);

    // Bouncing press: only the run starting at index 5 survives.
    foreach (bvec[i]) drive(bvec[i], 1, (i == 5));
    drive(1'b1, 10, 1'b0);
    drive(1'b0, 12, 1'b1);

    // Short highs: 3 and 4 samples are rejected, 5 samples are accepted.
    drive(1'b1, 3, 1'b0);
    drive(1'b0, 12, 1'b0);
    drive(1'b1, 4, 1'b0);
    drive(1'b0, 12, 1'b0);
    drive(1'b1, 5, 1'b1);
    drive(1'b0, 12, 1'b1);

    // Reset two edges into a pending rise; the rise must restart afterwards.
    @(negedge clk);
    btn_raw = 1'b1;
    k = cyc + 1;
    while (cyc < k + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midcount_rst_level", btn_level, 1'b0);
    check("midcount_rst_rise", btn_rise, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{edge_n: cyc + 1 + LAT, rise: 1'b1});
    repeat (12) @(negedge clk);

    // Reset while the debounced level is high clears it without a clock.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", btn_level, 1'b0);
    check("async_rst_fall", btn_fall, 1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
    check("async_rst_toggle", btn_toggle, 1'b0);
`endif
    btn_raw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 10, 1'b0);

    // Three full presses (toggle goes 1, 0, 1 when present).
    repeat (3) begin
      drive(1'b1, 10, 1'b1);
      drive(1'b0, 10, 1'b1);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", (sb.size() == 0), 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
